titan_pipeline_ctrl: RTL

- Consumes the per-cause stall requests raised by the hazard-detection logic, plus memory busy flags.
- Produces per-stage stall (hold) and flush (bubble) controls for the 5-stage IF/ID/EX/MEM/WB pipeline.
- Sequences exception entry: drains the excepting instruction to MEM, handshakes the trap with the CSR unit, then redirects fetch.

---
 rtl/titan_ctrl_pkg.sv | 35 +++
 rtl/titan_pipeline_ctrl_if.sv | 55 +++++
 rtl/titan_stall_mux.sv | 75 +++++++
 rtl/titan_pipeline_ctrl.sv | 123 ++++++++++++
 4 files changed

// File: rtl/titan_ctrl_pkg.sv
// Shared types for the titan pipeline controller: FSM state encoding,
// hazard request bundle, and bit indices of the stall/flush vectors.
package titan_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_DRAIN    = 2'd1,
        ST_TRAP     = 2'd2,
        ST_REDIRECT = 2'd3
    } state_e;

    // Stall vector covers the stages that can hold: IF..MEM.
    localparam int SI_IF  = 0;
    localparam int SI_ID  = 1;
    localparam int SI_EX  = 2;
    localparam int SI_MEM = 3;
    localparam int STALL_W = 4;

    // Flush vector covers the stage registers that can take a bubble: ID..WB.
    localparam int FI_ID  = 0;
    localparam int FI_EX  = 1;
    localparam int FI_MEM = 2;
    localparam int FI_WB  = 3;
    localparam int FLUSH_W = 4;

    typedef struct packed {
        logic illegal;
        logic xcall;
        logic csr;
        logic ld;
        logic ifetch_busy;
        logic dmem_busy;
    } req_t;

endpackage

// File: rtl/titan_pipeline_ctrl_if.sv
// Request/control bundle between hazard logic, CSR unit and the pipeline controller.
// Optional performance counter ports appear when TITAN_PIPE_PERF_EN is defined.
interface titan_pipeline_ctrl_if;

    logic illegal_stall_req_i;
    logic xcall_break_stall_req_i;
    logic csr_stall_req_i;
    logic ld_stall_req_i;
    logic mem_exc_i;
    logic ifetch_busy_i;
    logic dmem_busy_i;
    logic trap_ack_i;

    logic if_stall_o;
    logic id_stall_o;
    logic ex_stall_o;
    logic mem_stall_o;
    logic id_flush_o;
    logic ex_flush_o;
    logic mem_flush_o;
    logic wb_flush_o;
    logic trap_req_o;
    logic pc_redirect_o;
    logic drain_timeout_o;

`ifdef TITAN_PIPE_PERF_EN
    logic [31:0] stall_cycles_o;
    logic [15:0] trap_count_o;
`endif

    // Master: the hazard unit / CSR side that raises requests.
    modport master (
`ifdef TITAN_PIPE_PERF_EN
        input  stall_cycles_o, trap_count_o,
`endif
        output illegal_stall_req_i, xcall_break_stall_req_i, csr_stall_req_i,
        output ld_stall_req_i, mem_exc_i, ifetch_busy_i, dmem_busy_i, trap_ack_i,
        input  if_stall_o, id_stall_o, ex_stall_o, mem_stall_o,
        input  id_flush_o, ex_flush_o, mem_flush_o, wb_flush_o,
        input  trap_req_o, pc_redirect_o, drain_timeout_o
    );

    // Slave: the pipeline controller itself.
    modport slave (
`ifdef TITAN_PIPE_PERF_EN
        output stall_cycles_o, trap_count_o,
`endif
        input  illegal_stall_req_i, xcall_break_stall_req_i, csr_stall_req_i,
        input  ld_stall_req_i, mem_exc_i, ifetch_busy_i, dmem_busy_i, trap_ack_i,
        output if_stall_o, id_stall_o, ex_stall_o, mem_stall_o,
        output id_flush_o, ex_flush_o, mem_flush_o, wb_flush_o,
        output trap_req_o, pc_redirect_o, drain_timeout_o
    );

endinterface

// File: rtl/titan_stall_mux.sv
// Combinational map from controller state and hazard requests to the
// per-stage stall (hold) and flush (bubble) vectors; stall masks flush.
module titan_stall_mux
    import titan_ctrl_pkg::*;
(
    input  state_e              state,
    input  req_t                req,
    output logic [STALL_W-1:0]  stall,
    output logic [FLUSH_W-1:0]  flush
);

    logic [STALL_W-1:0] stall_raw;
    logic [FLUSH_W-1:0] flush_raw;

    always_comb begin
        stall_raw = '0;
        flush_raw = '0;
        unique case (state)
            ST_RUN: begin
                if (req.illegal || req.xcall) begin
                    stall_raw[SI_IF] = 1'b1;
                    flush_raw[FI_ID] = 1'b1;
                end else if (req.dmem_busy) begin
                    stall_raw        = '1;
                    flush_raw[FI_WB] = 1'b1;
                end else if (req.ld || req.csr) begin
                    stall_raw[SI_IF] = 1'b1;
                    stall_raw[SI_ID] = 1'b1;
                    flush_raw[FI_EX] = 1'b1;
                end else if (req.ifetch_busy) begin
                    stall_raw[SI_IF] = 1'b1;
                    flush_raw[FI_ID] = 1'b1;
                end
            end
            ST_DRAIN: begin
                // Fetch frozen, ID bubbled; older instructions keep moving unless dmem holds them.
                stall_raw[SI_IF] = 1'b1;
                flush_raw[FI_ID] = 1'b1;
                if (req.dmem_busy) begin
                    stall_raw[SI_EX]  = 1'b1;
                    stall_raw[SI_MEM] = 1'b1;
                    flush_raw[FI_WB]  = 1'b1;
                end
            end
            ST_TRAP: begin
                stall_raw[SI_IF]  = 1'b1;
                flush_raw[FI_ID]  = 1'b1;
                flush_raw[FI_EX]  = 1'b1;
                flush_raw[FI_MEM] = 1'b1;
            end
            ST_REDIRECT: begin
                flush_raw[FI_ID] = 1'b1;
                flush_raw[FI_EX] = 1'b1;
            end
            default: begin
                stall_raw = '0;
                flush_raw = '0;
            end
        endcase
    end

    assign stall = stall_raw;

    // Flush bit gi is the stage one past stall bit gi; WB has no stall.
    generate
        for (genvar gi = 0; gi < FLUSH_W; gi++) begin : g_mask
            if (gi < STALL_W - 1) begin : g_held
                assign flush[gi] = flush_raw[gi] & ~stall_raw[gi+1];
            end else begin : g_free
                assign flush[gi] = flush_raw[gi];
            end
        end
    endgenerate

endmodule

// File: rtl/titan_pipeline_ctrl.sv
// Pipeline stall/flush controller with exception drain/trap/redirect sequencing.
// Define TITAN_PIPE_PERF_EN to add the stall-cycle and trap performance counters.
module titan_pipeline_ctrl
    import titan_ctrl_pkg::*;
#(
    parameter int DRAIN_TIMEOUT = 8,
    parameter int CNT_W         = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    titan_pipeline_ctrl_if.slave bus
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DRAIN_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    state_e             state_reg;
    logic [CNT_W-1:0]   cnt_reg;
    logic               trap_req_reg;
    logic               pc_redirect_reg;
    logic               drain_timeout_reg;

    req_t               req;
    logic [STALL_W-1:0] stall_vec;
    logic [FLUSH_W-1:0] flush_vec;

    assign req.illegal     = bus.illegal_stall_req_i;
    assign req.xcall       = bus.xcall_break_stall_req_i;
    assign req.csr         = bus.csr_stall_req_i;
    assign req.ld          = bus.ld_stall_req_i;
    assign req.ifetch_busy = bus.ifetch_busy_i;
    assign req.dmem_busy   = bus.dmem_busy_i;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_reg         <= ST_RUN;
            cnt_reg           <= '0;
            trap_req_reg      <= 1'b0;
            pc_redirect_reg   <= 1'b0;
            drain_timeout_reg <= 1'b0;
        end else begin
            pc_redirect_reg   <= 1'b0;
            drain_timeout_reg <= 1'b0;
            unique case (state_reg)
                ST_RUN: begin
                    if (req.illegal || req.xcall) begin
                        state_reg <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (cnt_reg != CNT_MAX) begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                    // A pending dmem access must complete before the excepting op can trap.
                    if (bus.mem_exc_i && !req.dmem_busy) begin
                        state_reg    <= ST_TRAP;
                        trap_req_reg <= 1'b1;
                    end else if (cnt_reg == CNT_LAST) begin
                        state_reg         <= ST_TRAP;
                        trap_req_reg      <= 1'b1;
                        drain_timeout_reg <= 1'b1;
                    end
                end
                ST_TRAP: begin
                    if (bus.trap_ack_i) begin
                        state_reg       <= ST_REDIRECT;
                        trap_req_reg    <= 1'b0;
                        pc_redirect_reg <= 1'b1;
                    end
                end
                ST_REDIRECT: begin
                    state_reg <= ST_RUN;
                    cnt_reg   <= '0;
                end
                default: begin
                    state_reg <= ST_RUN;
                end
            endcase
        end
    end

    titan_stall_mux u_stall_mux (
        .state (state_reg),
        .req   (req),
        .stall (stall_vec),
        .flush (flush_vec)
    );

    assign bus.if_stall_o      = stall_vec[SI_IF];
    assign bus.id_stall_o      = stall_vec[SI_ID];
    assign bus.ex_stall_o      = stall_vec[SI_EX];
    assign bus.mem_stall_o     = stall_vec[SI_MEM];
    assign bus.id_flush_o      = flush_vec[FI_ID];
    assign bus.ex_flush_o      = flush_vec[FI_EX];
    assign bus.mem_flush_o     = flush_vec[FI_MEM];
    assign bus.wb_flush_o      = flush_vec[FI_WB];
    assign bus.trap_req_o      = trap_req_reg;
    assign bus.pc_redirect_o   = pc_redirect_reg;
    assign bus.drain_timeout_o = drain_timeout_reg;

`ifdef TITAN_PIPE_PERF_EN
    logic [31:0] stall_cycles_reg;
    logic [15:0] trap_count_reg;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            stall_cycles_reg <= '0;
            trap_count_reg   <= '0;
        end else begin
            if (stall_vec[SI_IF]) begin
                stall_cycles_reg <= stall_cycles_reg + 1'b1;
            end
            if (state_reg == ST_REDIRECT) begin
                trap_count_reg <= trap_count_reg + 1'b1;
            end
        end
    end

    assign bus.stall_cycles_o = stall_cycles_reg;
    assign bus.trap_count_o   = trap_count_reg;
`endif

endmodule
